// File: rtl/rs_station_gen2.sv
// rs_station_gen2: reservation station between issue and the ALU.
// Holds DEPTH pending ops, wakes busy operands from NUM_CDB broadcast
// channels, and dispatches the oldest ready entry through a valid/ready
// output register. Age order is kept in an age matrix: older_q[i][j] = 1
// means entry i was inserted before entry j.
// Optional feature macro: RS_DISPATCH_BYPASS_EN (ready inserts go straight
// to the output register when it can load and no resident entry is ready).
module rs_station_gen2 #(
  parameter int DEPTH       = 16,
  parameter int DATA_W      = 32,
  parameter int TAG_W       = 5,
  parameter int OP_W        = 6,
  parameter int NUM_CDB     = 2,
  parameter int FULL_MARGIN = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        clear,
  output logic                        full_o,
  output logic [$clog2(DEPTH):0]      count_o,
  input  logic                        in_valid,
  input  logic [OP_W-1:0]             in_op,
  input  logic [TAG_W-1:0]            in_tag,
  input  logic                        in_src1_busy,
  input  logic                        in_src2_busy,
  input  logic [TAG_W-1:0]            in_src1_tag,
  input  logic [TAG_W-1:0]            in_src2_tag,
  input  logic [DATA_W-1:0]           in_src1_val,
  input  logic [DATA_W-1:0]           in_src2_val,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_val,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OP_W-1:0]             out_op,
  output logic [DATA_W-1:0]           out_val1,
  output logic [DATA_W-1:0]           out_val2,
  output logic [TAG_W-1:0]            out_tag
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MARGIN_C = CNT_W'(FULL_MARGIN);

  // Entry storage
  logic [DEPTH-1:0]  valid_q, valid_d, s1_busy_q, s1_busy_d, s2_busy_q, s2_busy_d;
  logic [OP_W-1:0]   op_q [DEPTH], op_d [DEPTH];
  logic [TAG_W-1:0]  tag_q [DEPTH], tag_d [DEPTH];
  logic [TAG_W-1:0]  s1_tag_q [DEPTH], s1_tag_d [DEPTH], s2_tag_q [DEPTH], s2_tag_d [DEPTH];
  logic [DATA_W-1:0] s1_val_q [DEPTH], s1_val_d [DEPTH], s2_val_q [DEPTH], s2_val_d [DEPTH];
  logic [DEPTH-1:0]  older_q [DEPTH], older_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  // Output register
  logic              out_valid_q, out_valid_d;
  logic [OP_W-1:0]   out_op_q, out_op_d;
  logic [DATA_W-1:0] out_val1_q, out_val1_d, out_val2_q, out_val2_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;

  // Combinational helpers
  logic              in1_busy_s, in2_busy_s;
  logic [DATA_W-1:0] in1_val_s, in2_val_s;
  logic [DEPTH-1:0]  ready_s, sel_oh_s;
  logic [IDX_W-1:0]  sel_idx_s, free_idx_s;
  logic              any_ready_s, has_free_s, out_load_s, bypass_s, insert_s, dispatch_s;

  // Same-cycle wakeup of the incoming operands; lowest matching channel wins
  always_comb begin
    in1_busy_s = in_src1_busy;
    in1_val_s  = in_src1_val;
    in2_busy_s = in_src2_busy;
    in2_val_s  = in_src2_val;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      in1_val_s  = (cdb_valid[k] && in_src1_busy && cdb_tag[k*TAG_W +: TAG_W] == in_src1_tag)
                   ? cdb_val[k*DATA_W +: DATA_W] : in1_val_s;
      in1_busy_s = (cdb_valid[k] && in_src1_busy && cdb_tag[k*TAG_W +: TAG_W] == in_src1_tag)
                   ? 1'b0 : in1_busy_s;
      in2_val_s  = (cdb_valid[k] && in_src2_busy && cdb_tag[k*TAG_W +: TAG_W] == in_src2_tag)
                   ? cdb_val[k*DATA_W +: DATA_W] : in2_val_s;
      in2_busy_s = (cdb_valid[k] && in_src2_busy && cdb_tag[k*TAG_W +: TAG_W] == in_src2_tag)
                   ? 1'b0 : in2_busy_s;
    end
  end

  // Oldest-ready selection, lowest free slot, and load/insert decisions
  always_comb begin
    ready_s    = valid_q & ~s1_busy_q & ~s2_busy_q;
    sel_oh_s   = '0;
    sel_idx_s  = '0;
    free_idx_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic older_ready;
      older_ready = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        older_ready = older_ready | (ready_s[j] & older_q[j][i]);
      end
      sel_oh_s[i] = ready_s[i] & ~older_ready;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      sel_idx_s  = sel_oh_s[i] ? IDX_W'(i) : sel_idx_s;
      free_idx_s = !valid_q[i] ? IDX_W'(i) : free_idx_s;
    end
    any_ready_s = |ready_s;
    has_free_s  = ~(&valid_q);
    out_load_s  = !out_valid_q || out_ready;
    dispatch_s  = out_load_s && any_ready_s;
`ifdef RS_DISPATCH_BYPASS_EN
    bypass_s    = in_valid && !in1_busy_s && !in2_busy_s && out_load_s && !any_ready_s;
`else
    bypass_s    = 1'b0;
`endif
    insert_s    = in_valid && has_free_s && !bypass_s;
  end

  // Next-state: flush, freeze, or wakeup + dispatch + insert
  always_comb begin
    valid_d = valid_q;  s1_busy_d = s1_busy_q;  s2_busy_d = s2_busy_q;
    op_d = op_q;  tag_d = tag_q;  s1_tag_d = s1_tag_q;  s2_tag_d = s2_tag_q;
    s1_val_d = s1_val_q;  s2_val_d = s2_val_q;  older_d = older_q;
    count_d = count_q;
    out_valid_d = out_valid_q;  out_op_d = out_op_q;  out_tag_d = out_tag_q;
    out_val1_d = out_val1_q;  out_val2_d = out_val2_q;
    if (clear) begin
      valid_d     = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else if (!rdy_in) begin
      valid_d = valid_q;
    end else begin
      // resident wakeup; high-to-low walk so the lowest channel wins
      for (int i = 0; i < DEPTH; i++) begin
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
          s1_val_d[i]  = (valid_q[i] && s1_busy_q[i] && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == s1_tag_q[i])
                         ? cdb_val[k*DATA_W +: DATA_W] : s1_val_d[i];
          s1_busy_d[i] = (valid_q[i] && s1_busy_q[i] && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == s1_tag_q[i])
                         ? 1'b0 : s1_busy_d[i];
          s2_val_d[i]  = (valid_q[i] && s2_busy_q[i] && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == s2_tag_q[i])
                         ? cdb_val[k*DATA_W +: DATA_W] : s2_val_d[i];
          s2_busy_d[i] = (valid_q[i] && s2_busy_q[i] && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == s2_tag_q[i])
                         ? 1'b0 : s2_busy_d[i];
        end
      end
      // output register
      if (dispatch_s) begin
        out_valid_d        = 1'b1;
        out_op_d           = op_q[sel_idx_s];
        out_tag_d          = tag_q[sel_idx_s];
        out_val1_d         = s1_val_q[sel_idx_s];
        out_val2_d         = s2_val_q[sel_idx_s];
        valid_d[sel_idx_s] = 1'b0;
      end else if (bypass_s) begin
        out_valid_d = 1'b1;
        out_op_d    = in_op;
        out_tag_d   = in_tag;
        out_val1_d  = in1_val_s;
        out_val2_d  = in2_val_s;
      end else if (out_load_s) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
      // insert into lowest free slot; the newcomer is younger than everyone
      if (insert_s) begin
        valid_d[free_idx_s]   = 1'b1;
        op_d[free_idx_s]      = in_op;
        tag_d[free_idx_s]     = in_tag;
        s1_busy_d[free_idx_s] = in1_busy_s;
        s1_tag_d[free_idx_s]  = in_src1_tag;
        s1_val_d[free_idx_s]  = in1_val_s;
        s2_busy_d[free_idx_s] = in2_busy_s;
        s2_tag_d[free_idx_s]  = in_src2_tag;
        s2_val_d[free_idx_s]  = in2_val_s;
        older_d[free_idx_s]   = '0;
        for (int j = 0; j < DEPTH; j++) begin
          older_d[j][free_idx_s] = (j != int'(free_idx_s));
        end
      end else begin
        older_d = older_q;
      end
      count_d = count_q + {{(CNT_W-1){1'b0}}, insert_s} - {{(CNT_W-1){1'b0}}, dispatch_s};
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;  s1_busy_q <= '0;  s2_busy_q <= '0;
      op_q <= '{default: '0};  tag_q <= '{default: '0};
      s1_tag_q <= '{default: '0};  s2_tag_q <= '{default: '0};
      s1_val_q <= '{default: '0};  s2_val_q <= '{default: '0};
      older_q <= '{default: '0};
      count_q <= '0;
      out_valid_q <= 1'b0;  out_op_q <= '0;  out_tag_q <= '0;
      out_val1_q <= '0;  out_val2_q <= '0;
    end else begin
      valid_q <= valid_d;  s1_busy_q <= s1_busy_d;  s2_busy_q <= s2_busy_d;
      op_q <= op_d;  tag_q <= tag_d;
      s1_tag_q <= s1_tag_d;  s2_tag_q <= s2_tag_d;
      s1_val_q <= s1_val_d;  s2_val_q <= s2_val_d;
      older_q <= older_d;
      count_q <= count_d;
      out_valid_q <= out_valid_d;  out_op_q <= out_op_d;  out_tag_q <= out_tag_d;
      out_val1_q <= out_val1_d;  out_val2_q <= out_val2_d;
    end
  end

  assign count_o   = count_q;
  assign full_o    = (DEPTH_C - count_q) < MARGIN_C;
  assign out_valid = out_valid_q;
  assign out_op    = out_op_q;
  assign out_tag   = out_tag_q;
  assign out_val1  = out_val1_q;
  assign out_val2  = out_val2_q;
endmodule

// File: tb/tb_rs_station_gen2.sv
// Directed self-checking bench for rs_station_gen2 (default parameters).
module tb_rs_station_gen2;
  logic        clk_in = 1'b0, rst_in, rdy_in, clear;
  logic        full_o;
  logic [4:0]  count_o;
  logic        in_valid, in_src1_busy, in_src2_busy;
  logic [5:0]  in_op;
  logic [4:0]  in_tag, in_src1_tag, in_src2_tag;
  logic [31:0] in_src1_val, in_src2_val;
  logic [1:0]  cdb_valid;
  logic [9:0]  cdb_tag;
  logic [63:0] cdb_val;
  logic        out_valid, out_ready;
  logic [5:0]  out_op;
  logic [31:0] out_val1, out_val2;
  logic [4:0]  out_tag;
  int          n_total = 0;
  int          n_bad   = 0;

  rs_station_gen2 dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .full_o(full_o), .count_o(count_o),
    .in_valid(in_valid), .in_op(in_op), .in_tag(in_tag),
    .in_src1_busy(in_src1_busy), .in_src2_busy(in_src2_busy),
    .in_src1_tag(in_src1_tag), .in_src2_tag(in_src2_tag),
    .in_src1_val(in_src1_val), .in_src2_val(in_src2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_val1(out_val1), .out_val2(out_val2), .out_tag(out_tag)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic ins(input logic [4:0] t, input logic [5:0] op,
                     input logic b1, input logic [4:0] t1, input logic [31:0] v1,
                     input logic b2, input logic [4:0] t2, input logic [31:0] v2);
    in_valid = 1'b1;  in_tag = t;  in_op = op;
    in_src1_busy = b1;  in_src1_tag = t1;  in_src1_val = v1;
    in_src2_busy = b2;  in_src2_tag = t2;  in_src2_val = v2;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0;  rdy_in = 1'b1;  clear = 1'b0;  in_valid = 1'b0;
    in_op = '0;  in_tag = '0;  in_src1_busy = 1'b0;  in_src2_busy = 1'b0;
    in_src1_tag = '0;  in_src2_tag = '0;  in_src1_val = '0;  in_src2_val = '0;
    cdb_valid = '0;  cdb_tag = '0;  cdb_val = '0;  out_ready = 1'b1;
    #2;
    chk_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk_eq("rst_count", {27'b0, count_o}, 32'd0);
    chk_eq("rst_full", {31'b0, full_o}, 32'd0);
    chk_eq("rst_out_tag", {27'b0, out_tag}, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    step();

    // ready insert: latency 1 edge with bypass, 2 without
    ins(5'd3, 6'h01, 1'b0, 5'd0, 32'd5, 1'b0, 5'd0, 32'd7);
`ifdef RS_DISPATCH_BYPASS_EN
    chk_eq("add_count_bypass", {27'b0, count_o}, 32'd0);
`else
    chk_eq("add_not_yet", {31'b0, out_valid}, 32'd0);
    chk_eq("add_stored", {27'b0, count_o}, 32'd1);
    step();
`endif
    chk_eq("add_valid", {31'b0, out_valid}, 32'd1);
    chk_eq("add_val1", out_val1, 32'd5);
    chk_eq("add_val2", out_val2, 32'd7);
    chk_eq("add_tag", {27'b0, out_tag}, 32'd3);
    chk_eq("add_op", {26'b0, out_op}, 32'h01);
    step();
    chk_eq("add_drain", {31'b0, out_valid}, 32'd0);

    // younger entry woken first dispatches first
    ins(5'd4, 6'h02, 1'b1, 5'd9, 32'd0, 1'b0, 5'd0, 32'd0);
    ins(5'd6, 6'h02, 1'b1, 5'd10, 32'd0, 1'b0, 5'd0, 32'd0);
    chk_eq("wake_count", {27'b0, count_o}, 32'd2);
    cdb_valid = 2'b10;  cdb_tag = {5'd10, 5'd0};  cdb_val = {32'hAA, 32'h0};
    step();
    cdb_valid = 2'b01;  cdb_tag = {5'd0, 5'd9};  cdb_val = {32'h0, 32'hBB};
    step();
    cdb_valid = 2'b00;
    chk_eq("wake_first_tag", {27'b0, out_tag}, 32'd6);
    chk_eq("wake_first_val", out_val1, 32'hAA);
    step();
    chk_eq("wake_second_tag", {27'b0, out_tag}, 32'd4);
    chk_eq("wake_second_val", out_val1, 32'hBB);
    step();
    chk_eq("wake_drain", {31'b0, out_valid}, 32'd0);
    chk_eq("wake_count0", {27'b0, count_o}, 32'd0);

    // same-cycle wakeup on insert
    cdb_valid = 2'b01;  cdb_tag = {5'd0, 5'd8};  cdb_val = {32'h0, 32'h1234};
    ins(5'd2, 6'h03, 1'b1, 5'd8, 32'd0, 1'b0, 5'd0, 32'd1);
    cdb_valid = 2'b00;
`ifndef RS_DISPATCH_BYPASS_EN
    chk_eq("sc_stored", {27'b0, count_o}, 32'd1);
    step();
`endif
    chk_eq("sc_valid", {31'b0, out_valid}, 32'd1);
    chk_eq("sc_tag", {27'b0, out_tag}, 32'd2);
    chk_eq("sc_val1", out_val1, 32'h1234);
    step();

    // backpressure: outputs stable, then oldest-first drain
    out_ready = 1'b0;
    ins(5'd11, 6'h04, 1'b0, 5'd0, 32'd11, 1'b0, 5'd0, 32'd0);
    ins(5'd12, 6'h04, 1'b0, 5'd0, 32'd12, 1'b0, 5'd0, 32'd0);
    ins(5'd13, 6'h04, 1'b0, 5'd0, 32'd13, 1'b0, 5'd0, 32'd0);
    chk_eq("bp_count", {27'b0, count_o}, 32'd2);
    for (int c = 0; c < 10; c++) begin
      chk_eq("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      chk_eq("bp_hold_tag", {27'b0, out_tag}, 32'd11);
      chk_eq("bp_hold_val", out_val1, 32'd11);
      step();
    end
    out_ready = 1'b1;
    step();
    chk_eq("bp_rel1", {27'b0, out_tag}, 32'd12);
    step();
    chk_eq("bp_rel2", {27'b0, out_tag}, 32'd13);
    step();
    chk_eq("bp_empty", {31'b0, out_valid}, 32'd0);

    // fill toward full, dispatch one, overfill, then clear
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i == 14) chk_eq("fill14_full", {31'b0, full_o}, 32'd0);
      ins(5'(i), 6'h05, 1'b1, 5'(i + 16), 32'd0, 1'b0, 5'd0, 32'(i));
    end
    chk_eq("fill15_count", {27'b0, count_o}, 32'd15);
    chk_eq("fill15_full", {31'b0, full_o}, 32'd1);
    cdb_valid = 2'b01;  cdb_tag = {5'd0, 5'd16};  cdb_val = {32'h0, 32'h55};
    step();
    cdb_valid = 2'b00;
    step();
    chk_eq("disp_count", {27'b0, count_o}, 32'd14);
    chk_eq("disp_full", {31'b0, full_o}, 32'd0);
    chk_eq("disp_tag", {27'b0, out_tag}, 32'd0);
    chk_eq("disp_val", out_val1, 32'h55);
    ins(5'd20, 6'h05, 1'b1, 5'd31, 32'd0, 1'b0, 5'd0, 32'd0);
    ins(5'd21, 6'h05, 1'b1, 5'd31, 32'd0, 1'b0, 5'd0, 32'd0);
    chk_eq("full16_count", {27'b0, count_o}, 32'd16);
    ins(5'd22, 6'h05, 1'b1, 5'd31, 32'd0, 1'b0, 5'd0, 32'd0);
    chk_eq("overfill_drop", {27'b0, count_o}, 32'd16);
    clear = 1'b1;
    ins(5'd23, 6'h05, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    clear = 1'b0;
    chk_eq("clear_count", {27'b0, count_o}, 32'd0);
    chk_eq("clear_valid", {31'b0, out_valid}, 32'd0);

    // rdy_in low freezes everything
    rdy_in = 1'b0;
    ins(5'd7, 6'h06, 1'b0, 5'd0, 32'd1, 1'b0, 5'd0, 32'd2);
    step();
    chk_eq("freeze_count", {27'b0, count_o}, 32'd0);
    chk_eq("freeze_valid", {31'b0, out_valid}, 32'd0);
    rdy_in = 1'b1;

    // asynchronous reset mid-operation
    ins(5'd1, 6'h07, 1'b0, 5'd0, 32'd9, 1'b0, 5'd0, 32'd9);
    for (int i = 0; i < 5; i++) begin
      ins(5'(i + 24), 6'h07, 1'b1, 5'd31, 32'd0, 1'b0, 5'd0, 32'd0);
    end
    chk_eq("pre_rst_count", {27'b0, count_o}, 32'd5);
    chk_eq("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst_in = 1'b0;
    #1;
    chk_eq("async_rst_valid", {31'b0, out_valid}, 32'd0);
    chk_eq("async_rst_count", {27'b0, count_o}, 32'd0);
    chk_eq("async_rst_full", {31'b0, full_o}, 32'd0);
    chk_eq("async_rst_val1", out_val1, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/rs_station_gen2.md
Name: rs_station_gen2

Overview:
Parametrised reservation station between the issue stage and the ALU in the Tomasulo core. Holds up to DEPTH pending ops, captures source operands from NUM_CDB broadcast channels, and dispatches the oldest ready entry through a valid/ready output register. Compared with the first-generation station it adds configurable depth and widths, multi-channel wakeup, age-ordered selection, ALU backpressure and an occupancy count.

Parameters:
DEPTH, 16, number of entries (power of two, >=2)
DATA_W, 32, operand width
TAG_W, 5, ROB tag width
OP_W, 6, opcode width
NUM_CDB, 2, number of wakeup/broadcast channels
FULL_MARGIN, 2, full_o asserts when free entries < FULL_MARGIN (1..DEPTH)

Ports:
clk_in  in  1  clock, rising edge
rst_in  in  1  asynchronous, active-low reset
rdy_in  in  1  global enable; low freezes all state
clear  in  1  synchronous flush (misprediction)
full_o  out  1  issue must hold off
count_o  out  $clog2(DEPTH)+1  occupied entries
in_valid  in  1  insert request
in_op  in  OP_W  opcode
in_tag  in  TAG_W  destination ROB tag
in_src1_busy / in_src2_busy  in  1  operand still pending
in_src1_tag / in_src2_tag  in  TAG_W  producing ROB tag when busy
in_src1_val / in_src2_val  in  DATA_W  operand value when not busy
cdb_valid  in  NUM_CDB  per-channel broadcast valid
cdb_tag  in  NUM_CDB*TAG_W  channel k at [k*TAG_W +: TAG_W]
cdb_val  in  NUM_CDB*DATA_W  channel k at [k*DATA_W +: DATA_W]
out_valid  out  1  dispatch valid
out_ready  in  1  ALU accepts
out_op  out  OP_W
out_val1 / out_val2  out  DATA_W
out_tag  out  TAG_W

Behaviour:
- Reset (rst_in low, async): all entries invalid; out_valid=0, out_op/out_val1/out_val2/out_tag=0, count_o=0, full_o=0.
- Priority: reset > clear > !rdy_in (hold) > normal. clear invalidates all entries and drops out_valid at the edge; the concurrent insert is discarded.
- Per entry: valid, op, tag, per source {busy, tag, val}, age order.
- Insert: in_valid and a free entry -> lowest-index free entry written at the edge. in_valid with no free entry is a protocol violation: request dropped, state unchanged.
- Same-cycle wakeup on insert: an incoming busy source whose tag matches any valid CDB channel is stored not-busy with that channel's value.
- Wakeup of resident entries: every valid entry, every busy source, every channel compared each cycle; a match clears busy and latches the value at the edge. If several channels match, the lowest index wins; tags are unique by protocol.
- Ready: valid and both sources not busy, evaluated on registered state. A source woken in cycle N makes the entry ready in N+1.
- Output register loads when !out_valid or (out_valid and out_ready): the oldest ready entry (earliest inserted) moves to out_*, its entry is freed at the same edge, and out_valid=1. If no entry is ready, out_valid=0.
- out_valid stays high and out_* stay stable while out_ready is low.
- Latency: insert with both operands ready at edge E0 -> out_valid high after E1 if the output register is free.
- A slot freed at edge E is allocatable from cycle E+1. Insert and dispatch in the same cycle: count_o unchanged.
- count_o = number of valid entries (registered). full_o is combinational: (DEPTH - count_o) < FULL_MARGIN.
- Age ordering must survive arbitrary insert/free interleaving. Implementation choice: an age matrix or per-entry sequence numbers with wrap handling.

Optional Feature:
RS_DISPATCH_BYPASS_EN. When defined, an incoming op whose sources are both ready after same-cycle wakeup goes straight into the output register at the edge and is never stored, if all of these hold:
- the output register can load this cycle;
- no resident entry is ready.
Latency from in_valid to out_valid is then 1 edge, and count_o is unchanged. When not defined, every op is stored first, giving a minimum latency of 2 edges.

Test Plan:
- Reset mid-operation with 5 entries and out_valid=1: assert rst_in low -> out_valid=0, count_o=0, full_o=0 immediately, without waiting for a clock edge.
- Insert tag 3, op ADD, src1=5, src2=7, both ready; out_ready=1 -> out_valid high 1 edge later (bypass on) or 2 edges later (bypass off); out_val1=5, out_val2=7, out_tag=3.
- Insert tag 4 waiting on tag 9, then tag 6 waiting on tag 10; broadcast cdb ch1 {10, 0xAA} then ch0 {9, 0xBB} -> tag 6 dispatches before tag 4; out_val1 values are 0xAA then 0xBB.
- Insert tag 2 waiting on tag 8 in the same cycle cdb ch0 broadcasts {8, 0x1234} -> entry stored ready; dispatched with out_val1=0x1234.
- Hold out_ready=0 with 3 ready entries -> out_* stable for 10 cycles; after release, entries dispatch oldest-first on consecutive cycles.
- DEPTH=16, FULL_MARGIN=2: fill to 15 entries -> full_o=1; dispatch one -> full_o=0 next cycle. Pulse clear -> count_o=0 and out_valid=0 after the edge.
